// File: rtl/irq_pkg.sv
// Shared register map, ICR field positions and FSM encoding for the interrupt controller.
package irq_pkg;

  localparam logic [31:0] IRQ_OFF_IER = 32'h0000_0000;
  localparam logic [31:0] IRQ_OFF_IPR = 32'h0000_0004;
  localparam logic [31:0] IRQ_OFF_ICR = 32'h0000_0008;

  localparam int ICR_GIE_BIT   = 0;
  localparam int ICR_CAUSE_LSB = 8;
  localparam int ICR_CAUSE_W   = 2;
  localparam int ICR_BUSY_BIT  = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  function automatic logic [31:0] icr_pack(input logic gie,
                                           input logic [ICR_CAUSE_W-1:0] cause,
                                           input logic busy);
    logic [31:0] v;
    v = '0;
    v[ICR_GIE_BIT] = gie;
    v[ICR_CAUSE_LSB +: ICR_CAUSE_W] = cause;
    v[ICR_BUSY_BIT] = busy;
    return v;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending interrupt vector.
module irq_prio_enc #(
  parameter int NSRC  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NSRC-1:0]  req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one assigned.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching interrupt controller: IER/IPR/ICR register file plus a three-state
// request handshake (IDLE, REQ, SERVICE) against the CPU kernel-mode flag.
//   state   | meaning
//   IDLE    | arbitrating enabled pending sources, irq_out low
//   REQ     | irq_out high, CAUSE latched, waiting for kernel entry
//   SERVICE | handler running (ker=1), BUSY reads 1
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NSRC      = 3,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_req,
  input  logic            ker,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq_out
);

  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [1:0]             state_q, state_d;
  logic [NSRC-1:0]        ier_q, ier_d;
  logic [NSRC-1:0]        ipr_q, ipr_d;
  logic [NSRC-1:0]        src_prev_q, src_prev_d;
  logic                   gie_q, gie_d;
  logic [ICR_CAUSE_W-1:0] cause_q, cause_d;
  logic                   irq_q, irq_d;

  logic                   hit_ier, hit_ipr, hit_icr;
  logic [NSRC-1:0]        src_edge;
  logic [NSRC-1:0]        pending;
  logic [NSRC-1:0]        cause_mask;
  logic [IDX_W-1:0]       prio_idx;
  logic                   prio_valid;
  logic                   unused_wdata;

  assign hit_ier = (addr == BASE_ADDR + IRQ_OFF_IER);
  assign hit_ipr = (addr == BASE_ADDR + IRQ_OFF_IPR);
  assign hit_icr = (addr == BASE_ADDR + IRQ_OFF_ICR);

  assign src_edge     = src_req & ~src_prev_q;
  assign pending      = ipr_q & ier_q;
  assign cause_mask   = {{(NSRC-1){1'b0}}, 1'b1} << cause_q;
  assign unused_wdata = ^wdata[31:NSRC];

  irq_prio_enc #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (pending),
    .idx   (prio_idx),
    .valid (prio_valid)
  );

  always_comb begin
    src_prev_d = src_req;
    ier_d      = ier_q;
    gie_d      = gie_q;
    ipr_d      = ipr_q;
    if (wr && hit_ier) ier_d = wdata[NSRC-1:0];
    if (wr && hit_icr) gie_d = wdata[ICR_GIE_BIT];
    if (wr && hit_ipr) ipr_d = ipr_d & ~wdata[NSRC-1:0];
    // A new edge outranks a same-cycle clear so no request is ever lost.
    ipr_d = ipr_d | src_edge;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    irq_d   = irq_q;
    case (state_q)
      ST_IDLE: begin
        irq_d = 1'b0;
        if (gie_q && !ker && prio_valid) begin
          state_d = ST_REQ;
          cause_d = ICR_CAUSE_W'(prio_idx);
          irq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (ker) begin
          state_d = ST_SERVICE;
          irq_d   = 1'b0;
        end else if (!gie_d || ((ier_d & ipr_d & cause_mask) == '0)) begin
          // Withdraw on the same edge that commits the disabling write.
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        irq_d = 1'b0;
        if (!ker) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ier_q      <= '0;
      ipr_q      <= '0;
      src_prev_q <= '0;
      gie_q      <= 1'b0;
      cause_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ier_q      <= ier_d;
      ipr_q      <= ipr_d;
      src_prev_q <= src_prev_d;
      gie_q      <= gie_d;
      cause_q    <= cause_d;
      irq_q      <= irq_d;
    end
  end

  // Kernel mode masks the request immediately, covering syscall/exception entry.
  assign irq_out = irq_q & ~ker;

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (hit_ier)      rdata = {{(32-NSRC){1'b0}}, ier_q};
      else if (hit_ipr) rdata = {{(32-NSRC){1'b0}}, ipr_q};
      else if (hit_icr) rdata = icr_pack(gie_q, cause_q, state_q == ST_SERVICE);
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register-access table plus handshake sequences.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int          NSRC = 3;
  localparam logic [31:0] BASE = 32'h4000_0020;
  localparam logic [31:0] A_IER = BASE + IRQ_OFF_IER;
  localparam logic [31:0] A_IPR = BASE + IRQ_OFF_IPR;
  localparam logic [31:0] A_ICR = BASE + IRQ_OFF_ICR;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_req;
  logic            ker, rd, wr;
  logic [31:0]     addr, wdata, rdata;
  logic            irq_out;

  always #5 clk = ~clk;

  irq_controller #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_req (src_req),
    .ker     (ker),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_out (irq_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          is_wr;
    bit          rd_en;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit w, bit r, logic [31:0] a, logic [31:0] d, string n);
    vec_t v;
    v.is_wr = w; v.rd_en = r; v.addr = a; v.data = d; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected read value queued at drive time, popped when rdata settles.
  task automatic rd_chk_en(input string name, input bit en, input logic [31:0] a,
                           input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    rd   = en;
    addr = a;
    #1;
    e = sb_q.pop_front();
    check(e.name, rdata, e.exp);
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_chk_en(name, 1'b1, a, exp);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; src_req = '0; ker = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; src_req = '0; ker = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

    tbl.push_back(mk(0, 1, A_IER,       32'h0,         "rst_ier"));
    tbl.push_back(mk(0, 1, A_IPR,       32'h0,         "rst_ipr"));
    tbl.push_back(mk(0, 1, A_ICR,       32'h0,         "rst_icr"));
    tbl.push_back(mk(1, 0, A_IER,       32'hFFFF_FFFF, "wr_ier_all"));
    tbl.push_back(mk(0, 1, A_IER,       32'h7,         "ier_masked"));
    tbl.push_back(mk(0, 0, A_IER,       32'h0,         "rd_gated"));
    tbl.push_back(mk(1, 0, A_ICR,       32'hFFFF_FFFF, "wr_icr_all"));
    tbl.push_back(mk(0, 1, A_ICR,       32'h1,         "icr_gie_only"));
    tbl.push_back(mk(0, 1, BASE + 12,   32'h0,         "unmapped_rd"));
    tbl.push_back(mk(1, 0, BASE + 12,   32'h0,         "wr_unmapped"));
    tbl.push_back(mk(0, 1, A_IER,       32'h7,         "ier_after_unmapped"));
    tbl.push_back(mk(1, 0, A_IER,       32'h5,         "wr_ier_5"));
    tbl.push_back(mk(0, 1, A_IER,       32'h5,         "ier_5"));
    tbl.push_back(mk(0, 1, BASE - 4,    32'h0,         "below_base_rd"));
    tbl.push_back(mk(1, 0, A_ICR,       32'h0,         "wr_icr_0"));
    tbl.push_back(mk(0, 1, A_ICR,       32'h0,         "icr_cleared"));
    tbl.push_back(mk(1, 0, A_IPR,       32'h7,         "wr_ipr_w1c"));
    tbl.push_back(mk(0, 1, A_IPR,       32'h0,         "ipr_w1c_no_set"));
    tbl.push_back(mk(1, 0, A_IER,       32'h0,         "wr_ier_0"));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_irq", {31'b0, irq_out}, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        wr_reg(tbl[i].addr, tbl[i].data);
      end else begin
        @(negedge clk);
        rd_chk_en(tbl[i].name, tbl[i].rd_en, tbl[i].addr, tbl[i].data);
      end
    end

    // Single source edge: IPR one clock later, irq_out one clock after that.
    do_reset();
    wr_reg(A_IER, 32'h7);
    wr_reg(A_ICR, 32'h1);
    @(negedge clk); #1 src_req = 3'b010;
    @(negedge clk);
    rd_chk("s1_ipr", A_IPR, 32'h2);
    check("s1_irq_early", {31'b0, irq_out}, 32'h0);
    @(negedge clk);
    check("s1_irq", {31'b0, irq_out}, 32'h1);
    rd_chk("s1_icr_cause1", A_ICR, 32'h0000_0101);
    #1 ker = 1'b1;
    #1 check("s1_ker_mask", {31'b0, irq_out}, 32'h0);
    @(negedge clk);
    rd_chk("s1_busy", A_ICR, 32'h0001_0101);
    wr_reg(A_IPR, 32'h2);
    @(negedge clk); #1 ker = 1'b0; src_req = '0;
    repeat (3) @(negedge clk);
    check("s1_idle_irq", {31'b0, irq_out}, 32'h0);
    rd_chk("s1_ipr_clr", A_IPR, 32'h0);

    // Simultaneous edges: bit 0 wins, then bit 2 after service.
    do_reset();
    wr_reg(A_IER, 32'h7);
    wr_reg(A_ICR, 32'h1);
    @(negedge clk); #1 src_req = 3'b101;
    @(negedge clk);
    rd_chk("s2_ipr_both", A_IPR, 32'h5);
    @(negedge clk);
    check("s2_irq", {31'b0, irq_out}, 32'h1);
    rd_chk("s2_cause0", A_ICR, 32'h0000_0001);
    #1 ker = 1'b1;
    @(negedge clk);
    wr_reg(A_IPR, 32'h1);
    @(negedge clk); #1 ker = 1'b0;
    @(negedge clk);
    check("s2_rearb_gap", {31'b0, irq_out}, 32'h0);
    @(negedge clk);
    check("s2_irq2", {31'b0, irq_out}, 32'h1);
    rd_chk("s2_cause2", A_ICR, 32'h0000_0201);
    rd_chk("s2_ipr_left", A_IPR, 32'h4);

    // Disable in REQ before kernel entry withdraws the request.
    wr_reg(A_IER, 32'h0);
    check("s3_irq_drop", {31'b0, irq_out}, 32'h0);
    rd_chk("s3_ipr_kept", A_IPR, 32'h4);
    repeat (2) @(negedge clk);
    check("s3_idle_hold", {31'b0, irq_out}, 32'h0);
    rd_chk("s3_not_busy", A_ICR, 32'h0000_0201);
    wr_reg(A_IER, 32'h4);
    @(negedge clk);
    check("s3_arb_delay", {31'b0, irq_out}, 32'h0);
    @(negedge clk);
    check("s3_rearm", {31'b0, irq_out}, 32'h1);

    // Edge set and W1C on the same bit in the same cycle.
    do_reset();
    @(negedge clk); #1 src_req = 3'b100;
    @(negedge clk);
    rd_chk("s4_ipr_set", A_IPR, 32'h4);
    #1 src_req = '0;
    @(negedge clk); #1;
    src_req = 3'b100; wr = 1'b1; addr = A_IPR; wdata = 32'h4;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
    rd_chk("s4_set_wins", A_IPR, 32'h4);
    wr_reg(A_IPR, 32'h4);
    rd_chk("s4_w1c", A_IPR, 32'h0);

    // Edge during kernel mode waits until ker drops.
    do_reset();
    wr_reg(A_IER, 32'h7);
    wr_reg(A_ICR, 32'h1);
    @(negedge clk); #1 ker = 1'b1; src_req = 3'b001;
    @(negedge clk); #1 src_req = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("s5_ker_hold%0d", i), {31'b0, irq_out}, 32'h0);
    end
    rd_chk("s5_ipr", A_IPR, 32'h1);
    rd_chk("s5_stays_idle", A_ICR, 32'h1);
    #1 ker = 1'b0;
    @(negedge clk);
    check("s5_irq_after_ker", {31'b0, irq_out}, 32'h1);

    // Asynchronous reset while in REQ, then again while in SERVICE.
    #1 reset = 1'b1;
    #1 check("s6_async_req", {31'b0, irq_out}, 32'h0);
    @(negedge clk); reset = 1'b0;
    wr_reg(A_IER, 32'h7);
    wr_reg(A_ICR, 32'h1);
    @(negedge clk); #1 src_req = 3'b010;
    @(negedge clk);
    @(negedge clk);
    check("s6_req", {31'b0, irq_out}, 32'h1);
    #1 ker = 1'b1;
    @(negedge clk);
    rd_chk("s6_busy", A_ICR, 32'h0001_0001 | 32'h0000_0100);
    #1 reset = 1'b1;
    #1 check("s6_async_srv", {31'b0, irq_out}, 32'h0);
    rd_chk("s6_rst_ier", A_IER, 32'h0);
    rd_chk("s6_rst_ipr", A_IPR, 32'h0);
    rd_chk("s6_rst_icr", A_ICR, 32'h0);
    @(negedge clk); reset = 1'b0; ker = 1'b0; src_req = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NSRC, default 3, number of interrupt sources (bit 0 = timer, 1 = UART RX, 2 = UART TX done).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h40000020, byte address of the first register.
REQ-003 SHALL have port clk, input, 1, system clock; sole clock domain.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port src_req, input, NSRC, level requests from peripherals, synchronous to clk.
REQ-006 SHALL have port ker, input, 1, CPU kernel-mode flag (PC bit 31).
REQ-007 SHALL have port rd, input, 1, bus read strobe.
REQ-008 SHALL have port wr, input, 1, bus write strobe.
REQ-009 SHALL have port addr, input, 32, bus byte address.
REQ-010 SHALL have port wdata, input, 32, bus write data.
REQ-011 SHALL have port rdata, output, 32, bus read data.
REQ-012 SHALL have port irq_out, output, 1, interrupt request to the CPU control unit.

Function
REQ-013 SHALL detect a rising edge of each src_req bit against its previous-cycle value and set the matching IPR bit on the next clk edge.
REQ-014 SHALL map IER at BASE_ADDR (R/W, bits [NSRC-1:0]), IPR at BASE_ADDR+4 (read; write-1-to-clear) and ICR at BASE_ADDR+8 (bit 0 GIE R/W; bits [9:8] CAUSE read-only; bit 16 BUSY read-only).
REQ-015 SHALL drive rdata combinationally: register value zero-extended when rd=1 and addr matches; 32'h0 otherwise.
REQ-016 SHALL commit register writes on the clk edge where wr=1 and addr matches; unmatched addresses are ignored.
REQ-017 SHALL implement FSM IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ when GIE=1, ker=0 and (IPR & IER) != 0; CAUSE latched with the lowest set index of IPR & IER (fixed priority, bit 0 highest).
REQ-019 REQ SHALL assert irq_out=1 (registered, same cycle as state entry); REQ -> SERVICE when ker=1.
REQ-020 REQ -> IDLE with irq_out=0 if IER[CAUSE] or GIE is cleared, or IPR[CAUSE] is cleared, before ker rises.
REQ-021 SERVICE: irq_out=0, BUSY=1; SERVICE -> IDLE when ker=0; re-arbitration starts one cycle later.
REQ-022 SHALL assert irq_out=0 whenever ker=1, including when ker rises without a request (syscall or exception entry); the FSM stays IDLE in that case.
REQ-023 Simultaneous edge set and W1C clear of the same IPR bit: set SHALL win.
REQ-024 Pending edges arriving during REQ or SERVICE SHALL be retained in IPR and not change CAUSE.
REQ-025 Bits of wdata above NSRC-1 for IER/IPR SHALL be ignored; unimplemented bits read as 0.

Reset
REQ-026 On reset SHALL clear IER, IPR, GIE, CAUSE and the edge-history registers, enter IDLE and drive irq_out=0.
REQ-027 Reset asserted mid-REQ or mid-SERVICE SHALL drop irq_out in the same cycle (asynchronously).

Structure
REQ-028 SHALL take register offsets (IER=0, IPR=4, ICR=8), ICR bit positions and the FSM state encoding from a shared package, irq_pkg.
REQ-029 SHALL instantiate one sub-module, irq_prio_enc, a combinational lowest-index priority encoder (NSRC in, index plus valid out).

Verification
REQ-030 Reset, IER=3'b111, GIE=1, pulse src_req[1] -> IPR=3'b010 after 1 clk, irq_out=1 one clk later, CAUSE=1.
REQ-031 src_req=3'b101 rising in the same cycle -> CAUSE=0; after ker 0->1->0 and W1C of 3'b001, a second request is issued with CAUSE=2.
REQ-032 In REQ, write IER=0 before ker rises -> irq_out=0 next cycle, FSM in IDLE, IPR unchanged.
REQ-033 ker=1 with no pending interrupt, then pulse src_req[0] -> irq_out stays 0 until ker=0, then asserts.
REQ-034 W1C write of IPR=3'b100 in the same cycle as a src_req[2] edge -> IPR[2] stays 1.
REQ-035 Assert reset during SERVICE -> irq_out=0 immediately; all registers read 32'h0.
